// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit unsigned multiply / divide unit: shift-add MUL/MULHU, restoring DIVU/REMU.
// Divider datapath is present only when MULDIV_DIV_EN is defined; otherwise DIVU/REMU finish at once with 0.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  // Handshake: an op is taken when start_i=1 and flush_i=0 in IDLE; the pipeline is
  // frozen (stall_o) until the single done_o cycle, during which it advances exactly once.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] acc_q, q_q, opnd_q;
  logic [31:0] acc_d, q_d;
  logic        hi_q;
  logic        accept, bypass;
  logic [32:0] mul_sum;

`ifdef MULDIV_DIV_EN
  logic        div_q;
  logic [32:0] div_shift, div_diff;
  assign bypass = 1'b0;
`else
  assign bypass = op_i[1];
`endif

  assign accept = (state_q == IDLE) && start_i && !flush_i;

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q == CALC);
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            stall_o = 1'b1;
            state_d = bypass ? DONE : CALC;
          end
        end
        CALC: begin
          stall_o = 1'b1;
          // One setup cycle plus 32 bit-steps, so the exit test is on 32, not 31.
          if (cnt_q == 6'd32) state_d = DONE;
        end
        DONE: begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, opnd_q};
    if (q_q[0]) begin
      acc_d = mul_sum[32:1];
      q_d   = {mul_sum[0], q_q[31:1]};
    end else begin
      acc_d = {1'b0, acc_q[31:1]};
      q_d   = {acc_q[0], q_q[31:1]};
    end
`ifdef MULDIV_DIV_EN
    // Partial remainder stays below the divisor, so bit 32 of the difference is the borrow.
    div_shift = {acc_q, q_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (div_q) begin
      if (!div_diff[32]) begin
        acc_d = div_diff[31:0];
        q_d   = {q_q[30:0], 1'b1};
      end else begin
        acc_d = div_shift[31:0];
        q_d   = {q_q[30:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // q_q holds the multiplier / dividend and ends as product low word / quotient;
  // acc_q ends as product high word / remainder, so op_i[0] alone picks the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 6'd0;
      acc_q    <= 32'd0;
      q_q      <= 32'd0;
      opnd_q   <= 32'd0;
      hi_q     <= 1'b0;
      result_o <= 32'd0;
`ifdef MULDIV_DIV_EN
      div_q    <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q <= 6'd0;
      acc_q <= 32'd0;
      hi_q  <= op_i[0];
`ifdef MULDIV_DIV_EN
      div_q  <= op_i[1];
      q_q    <= op_i[1] ? a_i : b_i;
      opnd_q <= op_i[1] ? b_i : a_i;
`else
      q_q    <= b_i;
      opnd_q <= a_i;
`endif
      if (bypass) result_o <= 32'd0;
    end else if (state_q == CALC && !flush_i) begin
      if (cnt_q == 6'd32) begin
        result_o <= hi_q ? acc_q : q_q;
      end else begin
        acc_q <= acc_d;
        q_q   <= q_d;
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: clock, all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start_i, input, 1 bit: Execute-stage request valid, held high while the op sits in Execute.
REQ-004 The block SHALL have port op_i, input, 2 bits: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
REQ-005 The block SHALL have ports a_i and b_i, input, 32 bits each: forwarded operands, a_i is dividend/multiplicand, b_i is divisor/multiplier.
REQ-006 The block SHALL have port flush_i, input, 1 bit: branch-taken flush of the Execute stage.
REQ-007 The block SHALL have port stall_o, output, 1 bit: freezes the Fetch, Decode and Execute pipeline registers.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high in the CALC state.
REQ-009 The block SHALL have port done_o, output, 1 bit: one-cycle result-valid pulse.
REQ-010 The block SHALL have port result_o, output, 32 bits: unsigned result, valid when done_o=1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE; a 6-bit counter SHALL track iterations.
REQ-012 In IDLE with start_i=1 and flush_i=0, the block SHALL latch op_i, a_i and b_i, clear the counter and accumulator, and go to CALC.
REQ-013 In CALC, the block SHALL process one operand bit per cycle using a shift-add multiply or a restoring divide, for exactly 32 cycles, then go to DONE.
REQ-014 In DONE, the block SHALL assert done_o=1 for one cycle, drive result_o, and return to IDLE.
REQ-015 Latency SHALL be fixed: start_i accepted at edge 0 -> done_o high in the cycle after edge 33.
REQ-016 stall_o SHALL be (IDLE & start_i & ~flush_i) | CALC, and SHALL be 0 in DONE so the pipeline advances exactly once with the result.
REQ-017 start_i seen in DONE SHALL be ignored; a back-to-back op SHALL be accepted in the next IDLE cycle.
REQ-018 MUL SHALL return product[31:0] and MULHU SHALL return product[63:32] of the 64-bit unsigned product.
REQ-019 For divide by zero (b_i=0), DIVU SHALL return 0xFFFFFFFF and REMU SHALL return a_i, with no special-case latency.
REQ-020 flush_i=1 in any state SHALL force IDLE at the next edge, with no done_o pulse and stall_o=0 in that cycle.
REQ-021 result_o SHALL hold its last value outside DONE; the consumer SHALL ignore it unless done_o=1.

Reset
REQ-022 rst=0 SHALL immediately force IDLE, counter=0, operands/accumulator=0, result_o=0x00000000, done_o=0, busy_o=0, and stall_o=0 (given start_i=0).
REQ-023 Reset asserted mid-CALC SHALL abort the operation with no done_o pulse.

Configuration
REQ-024 With macro MULDIV_DIV_EN defined, the divider datapath SHALL be compiled in and DIVU/REMU SHALL behave per REQ-013..REQ-019.
REQ-025 Without MULDIV_DIV_EN, no divider logic SHALL exist, and op_i=1x SHALL go IDLE -> DONE in one cycle with result_o=0x00000000 (done_o after edge 1).

Verification
REQ-026 The bench SHALL cover: MUL a=7, b=6 -> done_o exactly once after edge 33, result_o=0x0000002A, stall_o high for cycles 0..33.
REQ-027 The bench SHALL cover: MULHU a=b=0xFFFFFFFF -> result_o=0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-028 The bench SHALL cover: DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005.
REQ-029 The bench SHALL cover: flush_i pulsed at CALC cycle 10 -> IDLE next cycle, no done_o, stall_o=0; a new MUL 3*3 then gives 0x00000009 after 33 cycles.
REQ-030 The bench SHALL cover: rst low at CALC cycle 20 -> all outputs at reset values immediately, no done_o after release.
REQ-031 The bench SHALL cover: two back-to-back MULs with start_i held -> two done_o pulses separated by 35 cycles, each op consumed once.
